exc_ctrl_unit: RTL and testbench

Parametrised, registered exception and interrupt controller for the commit stage of the MIPS32 pipeline. It synchronises the external interrupt lines and prioritises interrupts against the synchronous faults of the committing instruction. It then issues a one-cycle flush/redirect pulse together with the matching CP0 write strobes (EPC, BadVAddr, Cause.ExcCode/BD, Status.EXL). It sits between the memory/writeback stage and CP0; it generalises the old combinational exception logic with configurable interrupt counts, a commit FSM and an optional Count/Compare timer.

---
 rtl/exc_ctrl_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_exc_ctrl_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl_unit.sv
// exc_ctrl_unit: commit-stage exception and interrupt controller for the MIPS32 pipeline.
// Synchronises hw interrupt lines, prioritises interrupts against the committing
// instruction's faults and issues a one-cycle flush/redirect pulse with CP0 strobes.
// Optional feature: define TIMER_IRQ_EN to build the Count/Compare timer interrupt.
module exc_ctrl_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_HW_IRQ  = 6,
  parameter int              NUM_SW_IRQ  = 2,
  parameter int              SYNC_STAGES = 2,
  parameter logic [XLEN-1:0] EXC_VECTOR  = 32'hBFC0_0380
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_HW_IRQ-1:0]          hw_irq,
  input  logic [NUM_SW_IRQ-1:0]          sw_irq,
  input  logic [NUM_HW_IRQ+NUM_SW_IRQ-1:0] status_im,
  input  logic                           status_ie,
  input  logic                           status_exl,
  input  logic                           m_valid,
  input  logic                           m_is_ds,
  input  logic                           m_eret,
  input  logic [XLEN-1:0]                m_pc,
  input  logic [XLEN-1:0]                m_epc,
  input  logic [XLEN-1:0]                m_bad_addr,
  input  logic                           m_pc_misaligned,
  input  logic                           m_reserved,
  input  logic                           m_overflow,
  input  logic                           m_syscall,
  input  logic                           m_break,
  input  logic                           m_mem_addr_err,
  input  logic                           m_mem_write,
  input  logic                           stall,
  input  logic                           compare_we,
  input  logic                           count_we,
  input  logic [XLEN-1:0]                compare_wdata,
  input  logic [XLEN-1:0]                count_wdata,
  output logic                           exc_req,
  output logic                           flush,
  output logic [XLEN-1:0]                exc_target,
  output logic                           cp0_we_epc,
  output logic                           cp0_we_badvaddr,
  output logic                           cp0_we_cause,
  output logic                           cp0_set_exl,
  output logic                           cp0_clr_exl,
  output logic                           cp0_bd,
  output logic [XLEN-1:0]                cp0_epc,
  output logic [XLEN-1:0]                cp0_badvaddr,
  output logic [4:0]                     cp0_exccode,
  output logic [NUM_HW_IRQ+NUM_SW_IRQ-1:0] irq_pending,
  output logic [XLEN-1:0]                count_q
);

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_HW_IRQ-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_HW_IRQ-1:0]  hw_view;
  logic                   timer_pend;

  logic                   irq_take, eret_bad, fault_any, evt, capture;
  logic                   is_exc, badv_we_d;
  logic [4:0]             exccode_d;
  logic [XLEN-1:0]        badv_d, epc_d, epc_norm;

  logic                   vld_p1, we_epc_p1, we_bad_p1, we_cause_p1;
  logic                   set_exl_p1, clr_exl_p1, bd_p1;
  logic [XLEN-1:0]        target_p1, epc_p1, badv_p1;
  logic [4:0]             code_p1;

  // hw_irq synchroniser chain; the last stage is the visible Cause.IP hw view
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef TIMER_IRQ_EN
  logic [XLEN-1:0] count_r, compare_r;
  logic            tick_r;

  // Count advances on every second cycle; a Compare write always clears the pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= '0;
      compare_r  <= '0;
      tick_r     <= 1'b0;
      timer_pend <= 1'b0;
    end else begin
      tick_r <= ~tick_r;
      if (count_we)    count_r <= count_wdata;
      else if (tick_r) count_r <= count_r + 1'b1;
      if (compare_we)  compare_r <= compare_wdata;
      if (compare_we)                 timer_pend <= 1'b0;
      else if (count_r == compare_r)  timer_pend <= 1'b1;
    end
  end

  assign count_q = count_r;
`else
  logic unused_timer;
  assign unused_timer = ^{compare_we, count_we, compare_wdata, count_wdata};
  assign timer_pend   = 1'b0;
  assign count_q      = '0;
`endif

  // The timer interrupt shares the topmost hw line
  assign hw_view     = sync_q[SYNC_STAGES-1] | {timer_pend, {(NUM_HW_IRQ-1){1'b0}}};
  assign irq_pending = {hw_view, sw_irq};

  // Event detection and priority decode of the committing instruction
  always_comb begin
    irq_take  = (|(irq_pending & status_im)) & status_ie & ~status_exl;
    eret_bad  = m_eret & (m_epc[1:0] != 2'b00);
    fault_any = m_pc_misaligned | eret_bad | m_reserved | m_overflow |
                m_syscall | m_break | m_mem_addr_err;
    evt       = m_valid & (irq_take | fault_any | m_eret);
    epc_norm  = m_is_ds ? (m_pc - XLEN'(4)) : m_pc;

    is_exc    = 1'b1;
    exccode_d = EXC_INT;
    badv_we_d = 1'b0;
    badv_d    = '0;
    epc_d     = epc_norm;
    if (irq_take) begin
      exccode_d = EXC_INT;
    end else if (m_pc_misaligned) begin
      exccode_d = EXC_ADEL;
      badv_we_d = 1'b1;
      badv_d    = m_pc;
    end else if (eret_bad) begin
      exccode_d = EXC_ADEL;
      badv_we_d = 1'b1;
      badv_d    = m_epc;
      epc_d     = m_epc;
    end else if (m_reserved) begin
      exccode_d = EXC_RI;
    end else if (m_overflow) begin
      exccode_d = EXC_OV;
    end else if (m_syscall) begin
      exccode_d = EXC_SYS;
    end else if (m_break) begin
      exccode_d = EXC_BP;
    end else if (m_mem_addr_err) begin
      exccode_d = m_mem_write ? EXC_ADES : EXC_ADEL;
      badv_we_d = 1'b1;
      badv_d    = m_bad_addr;
    end else begin
      is_exc    = 1'b0;
      epc_d     = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; COMMIT blocks capture while the instruction is flushed
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_valid && !stall && evt) begin
          capture = 1'b1;
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p1: registered redirect pulse and CP0 strobes ----
  // Load on capture, otherwise clear so every strobe lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (rst || !capture) begin
      vld_p1      <= 1'b0;
      target_p1   <= '0;
      we_epc_p1   <= 1'b0;
      we_bad_p1   <= 1'b0;
      we_cause_p1 <= 1'b0;
      set_exl_p1  <= 1'b0;
      clr_exl_p1  <= 1'b0;
      bd_p1       <= 1'b0;
      epc_p1      <= '0;
      badv_p1     <= '0;
      code_p1     <= '0;
    end else begin
      vld_p1      <= 1'b1;
      target_p1   <= is_exc ? EXC_VECTOR : m_epc;
      we_epc_p1   <= is_exc & ~status_exl;
      we_bad_p1   <= badv_we_d;
      we_cause_p1 <= is_exc;
      set_exl_p1  <= is_exc;
      clr_exl_p1  <= ~is_exc;
      bd_p1       <= is_exc & m_is_ds;
      epc_p1      <= epc_d;
      badv_p1     <= badv_d;
      code_p1     <= is_exc ? exccode_d : 5'd0;
    end
  end

  assign exc_req         = vld_p1;
  assign flush           = vld_p1;
  assign exc_target      = target_p1;
  assign cp0_we_epc      = we_epc_p1;
  assign cp0_we_badvaddr = we_bad_p1;
  assign cp0_we_cause    = we_cause_p1;
  assign cp0_set_exl     = set_exl_p1;
  assign cp0_clr_exl     = clr_exl_p1;
  assign cp0_bd          = bd_p1;
  assign cp0_epc         = epc_p1;
  assign cp0_badvaddr    = badv_p1;
  assign cp0_exccode     = code_p1;

endmodule

// File: tb/tb_exc_ctrl_unit.sv
// Testbench for exc_ctrl_unit: directed scenarios plus randomized commit traffic
// checked against a priority-list reference model.
module tb_exc_ctrl_unit;
  localparam int NHW = 6;
  localparam int NSW = 2;
  localparam int NI  = 8;
  localparam int SS  = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk, rst;
  logic [NHW-1:0] hw_irq;
  logic [NSW-1:0] sw_irq;
  logic [NI-1:0]  status_im;
  logic status_ie, status_exl, m_valid, m_is_ds, m_eret;
  logic [31:0] m_pc, m_epc, m_bad_addr;
  logic m_pc_misaligned, m_reserved, m_overflow, m_syscall, m_break, m_mem_addr_err, m_mem_write;
  logic stall, compare_we, count_we;
  logic [31:0] compare_wdata, count_wdata;
  logic exc_req, flush;
  logic [31:0] exc_target;
  logic cp0_we_epc, cp0_we_badvaddr, cp0_we_cause, cp0_set_exl, cp0_clr_exl, cp0_bd;
  logic [31:0] cp0_epc, cp0_badvaddr;
  logic [4:0] cp0_exccode;
  logic [NI-1:0] irq_pending;
  logic [31:0] count_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        req;
    logic [31:0] target;
    logic [7:0]  strb;   // {we_epc, we_bad, we_cause, set_exl, clr_exl, bd, 2'b0}
    logic [31:0] epc;
    logic [31:0] badv;
    logic [4:0]  code;
  } exp_t;

  exc_ctrl_unit #(.XLEN(32), .NUM_HW_IRQ(NHW), .NUM_SW_IRQ(NSW), .SYNC_STAGES(SS),
                  .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .hw_irq(hw_irq), .sw_irq(sw_irq), .status_im(status_im),
    .status_ie(status_ie), .status_exl(status_exl), .m_valid(m_valid), .m_is_ds(m_is_ds),
    .m_eret(m_eret), .m_pc(m_pc), .m_epc(m_epc), .m_bad_addr(m_bad_addr),
    .m_pc_misaligned(m_pc_misaligned), .m_reserved(m_reserved), .m_overflow(m_overflow),
    .m_syscall(m_syscall), .m_break(m_break), .m_mem_addr_err(m_mem_addr_err),
    .m_mem_write(m_mem_write), .stall(stall), .compare_we(compare_we), .count_we(count_we),
    .compare_wdata(compare_wdata), .count_wdata(count_wdata), .exc_req(exc_req),
    .flush(flush), .exc_target(exc_target), .cp0_we_epc(cp0_we_epc),
    .cp0_we_badvaddr(cp0_we_badvaddr), .cp0_we_cause(cp0_we_cause),
    .cp0_set_exl(cp0_set_exl), .cp0_clr_exl(cp0_clr_exl), .cp0_bd(cp0_bd),
    .cp0_epc(cp0_epc), .cp0_badvaddr(cp0_badvaddr), .cp0_exccode(cp0_exccode),
    .irq_pending(irq_pending), .count_q(count_q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    hw_irq = '0; sw_irq = '0; status_im = '0; status_ie = 1'b0; status_exl = 1'b0;
    m_valid = 1'b0; m_is_ds = 1'b0; m_eret = 1'b0; m_pc = '0; m_epc = '0; m_bad_addr = '0;
    m_pc_misaligned = 1'b0; m_reserved = 1'b0; m_overflow = 1'b0; m_syscall = 1'b0;
    m_break = 1'b0; m_mem_addr_err = 1'b0; m_mem_write = 1'b0; stall = 1'b0;
    compare_we = 1'b0; count_we = 1'b0; compare_wdata = '0; count_wdata = '0;
  endtask

  // Expected outcome of committing the current m_* instruction, from the priority list
  function automatic exp_t ref_commit(input logic int_taken);
    exp_t e;
    logic [4:0] code;
    logic we_bad;
    logic [31:0] badv, epc;
    e.req = 1'b1;
    we_bad = 1'b0; badv = 32'd0;
    epc = m_is_ds ? m_pc - 32'd4 : m_pc;
    if (int_taken)                            code = 5'd0;
    else if (m_pc_misaligned) begin           code = 5'd4; we_bad = 1'b1; badv = m_pc; end
    else if (m_eret && m_epc[1:0] != 2'b00) begin
                                              code = 5'd4; we_bad = 1'b1; badv = m_epc; epc = m_epc; end
    else if (m_reserved)                      code = 5'd10;
    else if (m_overflow)                      code = 5'd12;
    else if (m_syscall)                       code = 5'd8;
    else if (m_break)                         code = 5'd9;
    else if (m_mem_addr_err) begin            code = m_mem_write ? 5'd5 : 5'd4; we_bad = 1'b1; badv = m_bad_addr; end
    else begin
      e.target = m_epc; e.strb = 8'b0000_1000; e.epc = 32'd0; e.badv = 32'd0; e.code = 5'd0;
      return e;
    end
    e.target = VEC;
    e.strb   = {!status_exl, we_bad, 1'b1, 1'b1, 1'b0, m_is_ds, 2'b00};
    e.epc    = epc;
    e.badv   = badv;
    e.code   = code;
    return e;
  endfunction

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if ({exc_req, flush, exc_target, cp0_we_epc, cp0_we_badvaddr, cp0_we_cause, cp0_set_exl,
         cp0_clr_exl, cp0_bd, cp0_epc, cp0_badvaddr, cp0_exccode, irq_pending, count_q} !== '0) begin
      $display("FAIL reset_outputs: req=%b target=%h code=%0d pend=%b count=%h required all zero",
               exc_req, exc_target, cp0_exccode, irq_pending, count_q);
      n_bad++;
    end
    n_cmp++;
    rst = 1'b0;
    @(negedge clk);
    if (exc_req !== 1'b0) begin
      $display("FAIL reset_release: exc_req=%b required 0", exc_req); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_overflow();
    drive_idle();
    m_valid = 1'b1; m_overflow = 1'b1; m_pc = 32'h8000_0100;
    @(negedge clk);
    drive_idle();
    if ({exc_req, flush, exc_target, cp0_exccode, cp0_epc, cp0_we_epc, cp0_set_exl,
         cp0_we_cause, cp0_we_badvaddr, cp0_clr_exl, cp0_bd} !==
        {1'b1, 1'b1, VEC, 5'd12, 32'h8000_0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL overflow: req=%b target=%h code=%0d epc=%h we_epc=%b required 1 %h 12 80000100 1",
               exc_req, exc_target, cp0_exccode, cp0_epc, cp0_we_epc, VEC);
      n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    if ({exc_req, flush, cp0_we_cause} !== 3'b000) begin
      $display("FAIL overflow_pulse_end: req=%b flush=%b we_cause=%b required 000", exc_req, flush, cp0_we_cause);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_syscall_ds();
    drive_idle();
    m_valid = 1'b1; m_syscall = 1'b1; m_is_ds = 1'b1; m_pc = 32'h8000_0204;
    @(negedge clk);
    drive_idle();
    if ({exc_req, cp0_exccode, cp0_epc, cp0_bd, exc_target} !== {1'b1, 5'd8, 32'h8000_0200, 1'b1, VEC}) begin
      $display("FAIL syscall_ds: req=%b code=%0d epc=%h bd=%b required 1 8 80000200 1",
               exc_req, cp0_exccode, cp0_epc, cp0_bd);
      n_bad++;
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_eret();
    drive_idle();
    m_valid = 1'b1; m_eret = 1'b1; m_epc = 32'h8000_0302;
    @(negedge clk);
    drive_idle();
    if ({exc_req, cp0_exccode, cp0_badvaddr, cp0_epc, cp0_we_badvaddr, exc_target, cp0_clr_exl} !==
        {1'b1, 5'd4, 32'h8000_0302, 32'h8000_0302, 1'b1, VEC, 1'b0}) begin
      $display("FAIL eret_misaligned: code=%0d badv=%h epc=%h we_bad=%b target=%h required 4 80000302 80000302 1 %h",
               cp0_exccode, cp0_badvaddr, cp0_epc, cp0_we_badvaddr, exc_target, VEC);
      n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    m_valid = 1'b1; m_eret = 1'b1; m_epc = 32'h8000_0300;
    @(negedge clk);
    drive_idle();
    if ({exc_req, exc_target, cp0_clr_exl, cp0_set_exl, cp0_we_epc, cp0_we_cause, cp0_we_badvaddr} !==
        {1'b1, 32'h8000_0300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL eret_plain: req=%b target=%h clr=%b set=%b we_epc=%b we_cause=%b required 1 80000300 1 0 0 0",
               exc_req, exc_target, cp0_clr_exl, cp0_set_exl, cp0_we_epc, cp0_we_cause);
      n_bad++;
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_irq_stall();
    drive_idle();
    status_ie = 1'b1; status_im = 8'b0000_0100; hw_irq = 6'b00_0001;
    @(negedge clk);
    if (irq_pending[2] !== 1'b0) begin
      $display("FAIL irq_sync_early: pend[2]=%b required 0", irq_pending[2]); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    if (irq_pending[2] !== 1'b1) begin
      $display("FAIL irq_sync_latency: pend[2]=%b required 1", irq_pending[2]); n_bad++;
    end
    n_cmp++;
    sw_irq = 2'b01;
    #1;
    if (irq_pending[1:0] !== 2'b01) begin
      $display("FAIL sw_irq_comb: pend[1:0]=%b required 01", irq_pending[1:0]); n_bad++;
    end
    n_cmp++;
    sw_irq = 2'b00;
    m_valid = 1'b1; m_break = 1'b1; m_pc = 32'h8000_0400; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (exc_req !== 1'b0) begin
        $display("FAIL stall_hold: cycle %0d exc_req=%b required 0", i, exc_req); n_bad++;
      end
      n_cmp++;
    end
    stall = 1'b0;
    @(negedge clk);
    drive_idle();
    if ({exc_req, cp0_exccode, cp0_epc, exc_target} !== {1'b1, 5'd0, 32'h8000_0400, VEC}) begin
      $display("FAIL irq_over_break: req=%b code=%0d epc=%h required 1 0 80000400", exc_req, cp0_exccode, cp0_epc);
      n_bad++;
    end
    n_cmp++;
    repeat (SS + 1) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic req_seq [4];
    req_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive_idle();
    status_exl = 1'b1; m_valid = 1'b1; m_syscall = 1'b1; m_pc = 32'h8000_0500;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({exc_req, cp0_we_epc, cp0_set_exl, cp0_we_cause} !== {req_seq[i], 1'b0, req_seq[i], req_seq[i]}) begin
        $display("FAIL back_to_back: cycle %0d req=%b we_epc=%b set_exl=%b required %b 0 %b",
                 i, exc_req, cp0_we_epc, cp0_set_exl, req_seq[i], req_seq[i]);
        n_bad++;
      end
      n_cmp++;
    end
    drive_idle();
    @(negedge clk);
    if (exc_req !== 1'b0) begin
      $display("FAIL back_to_back_end: req=%b required 0", exc_req); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_rst_commit();
    drive_idle();
    m_valid = 1'b1; m_overflow = 1'b1; m_pc = 32'h8000_0600;
    @(negedge clk);
    drive_idle();
    if (exc_req !== 1'b1) begin
      $display("FAIL rst_commit_pulse: req=%b required 1", exc_req); n_bad++;
    end
    n_cmp++;
    rst = 1'b1;
    @(negedge clk);
    if ({exc_req, flush, exc_target, cp0_we_cause, cp0_set_exl, cp0_epc, cp0_exccode} !== '0) begin
      $display("FAIL rst_commit_clear: req=%b target=%h epc=%h required all zero", exc_req, exc_target, cp0_epc);
      n_bad++;
    end
    n_cmp++;
    rst = 1'b0;
    @(negedge clk);
    if (exc_req !== 1'b0) begin
      $display("FAIL rst_commit_no_repeat: req=%b required 0", exc_req); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_timer();
`ifdef TIMER_IRQ_EN
    int n;
    drive_idle();
    compare_we = 1'b1; compare_wdata = 32'd10; count_we = 1'b1; count_wdata = 32'd0;
    @(negedge clk);
    compare_we = 1'b0; count_we = 1'b0;
    n = 0;
    while (irq_pending[NI-1] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n < 19 || n > 22 || (count_q !== 32'd10 && count_q !== 32'd11)) begin
      $display("FAIL timer_match: cycles=%0d count=%0d required 19..22 cycles count 10..11", n, count_q);
      n_bad++;
    end
    n_cmp++;
    compare_we = 1'b1; compare_wdata = 32'd10;
    @(negedge clk);
    compare_we = 1'b0;
    if (irq_pending[NI-1] !== 1'b0) begin
      $display("FAIL timer_clear: pend[top]=%b required 0", irq_pending[NI-1]); n_bad++;
    end
    n_cmp++;
    compare_we = 1'b1; compare_wdata = 32'hFFFF_FFF0;
    @(negedge clk);
    drive_idle();
`else
    drive_idle();
    hw_irq = 6'b10_0000; count_we = 1'b1; count_wdata = $urandom; compare_we = 1'b1; compare_wdata = 32'd0;
    repeat (SS) @(negedge clk);
    if ({irq_pending, count_q} !== {8'b1000_0000, 32'd0}) begin
      $display("FAIL timer_disabled: pend=%b count=%h required 10000000 00000000", irq_pending, count_q);
      n_bad++;
    end
    n_cmp++;
    drive_idle();
    repeat (SS) @(negedge clk);
    if (irq_pending !== 8'd0) begin
      $display("FAIL top_line_release: pend=%b required 0", irq_pending); n_bad++;
    end
    n_cmp++;
`endif
  endtask

  task automatic test_random(input int ncyc);
    logic [NHW-1:0] hist [$];
    logic [NHW-1:0] synced;
    logic [NI-1:0]  pend;
    logic           int_taken, any_evt;
    exp_t           ex;
    bit             busy;
    drive_idle();
    compare_we = 1'b1;
    repeat (SS + 3) @(negedge clk);
    for (int k = 0; k < SS; k++) hist.push_back('0);
    ex = '{req: 1'b0, target: 32'd0, strb: 8'd0, epc: 32'd0, badv: 32'd0, code: 5'd0};
    busy = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if ({exc_req, flush, exc_target, cp0_exccode, cp0_epc, cp0_badvaddr} !==
          {ex.req, ex.req, ex.target, ex.code, ex.epc, ex.badv} ||
          {cp0_we_epc, cp0_we_badvaddr, cp0_we_cause, cp0_set_exl, cp0_clr_exl, cp0_bd} !== ex.strb[7:2]) begin
        $display("FAIL random_commit: cyc %0d got req=%b tgt=%h code=%0d epc=%h badv=%h strb=%b%b%b%b%b%b want req=%b tgt=%h code=%0d epc=%h badv=%h strb=%b",
                 c, exc_req, exc_target, cp0_exccode, cp0_epc, cp0_badvaddr, cp0_we_epc, cp0_we_badvaddr,
                 cp0_we_cause, cp0_set_exl, cp0_clr_exl, cp0_bd, ex.req, ex.target, ex.code, ex.epc, ex.badv,
                 ex.strb[7:2]);
        n_bad++;
      end
      n_cmp++;
      synced = hist[hist.size() - SS];
      if ($urandom_range(0, 3) == 0) hw_irq = NHW'($urandom);
      hist.push_back(hw_irq);
      sw_irq          = ($urandom_range(0, 7) == 0) ? NSW'($urandom) : '0;
      status_im       = NI'($urandom);
      status_ie       = ($urandom_range(0, 2) == 0);
      status_exl      = ($urandom_range(0, 3) == 0);
      m_valid         = ($urandom_range(0, 3) != 0);
      m_is_ds         = $urandom_range(0, 1);
      m_eret          = ($urandom_range(0, 7) == 0);
      m_pc            = $urandom;
      m_epc           = $urandom;
      if ($urandom_range(0, 1) == 0) m_epc[1:0] = 2'b00;
      m_bad_addr      = $urandom;
      m_pc_misaligned = ($urandom_range(0, 9) == 0);
      m_reserved      = ($urandom_range(0, 9) == 0);
      m_overflow      = ($urandom_range(0, 9) == 0);
      m_syscall       = ($urandom_range(0, 9) == 0);
      m_break         = ($urandom_range(0, 9) == 0);
      m_mem_addr_err  = ($urandom_range(0, 9) == 0);
      m_mem_write     = $urandom_range(0, 1);
      stall           = ($urandom_range(0, 3) == 0);
      compare_wdata   = $urandom;
      #1;
      pend = {synced, sw_irq};
      if (irq_pending !== pend) begin
        $display("FAIL random_pending: cyc %0d got %b want %b", c, irq_pending, pend);
        n_bad++;
      end
      n_cmp++;
      int_taken = (|(pend & status_im)) && status_ie && !status_exl;
      any_evt   = int_taken || m_pc_misaligned || m_eret || m_reserved || m_overflow ||
                  m_syscall || m_break || m_mem_addr_err;
      if (!busy && m_valid && !stall && any_evt) begin
        ex = ref_commit(int_taken);
        busy = 1'b1;
      end else begin
        ex = '{req: 1'b0, target: 32'd0, strb: 8'd0, epc: 32'd0, badv: 32'd0, code: 5'd0};
        busy = 1'b0;
      end
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_overflow();
    test_syscall_ds();
    test_eret();
    test_irq_stall();
    test_back_to_back();
    test_rst_commit();
    test_timer();
    test_random(1500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
